// File: rtl/ddr_hit_judge.sv
// ddr_hit_judge: judges button presses against the displayed arrow once per
// metronome beat and keeps score, combo and max combo for the display.
module ddr_hit_judge #(
  parameter int NUM_ARROWS_BITS = 4,
  parameter int STATE_BITS      = 1,
  parameter int STATE_GAME      = 1,
  parameter int SCORE_MAX       = 9999,
  parameter int LOAD_DELAY      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     metronome_clk,
  input  logic [STATE_BITS:0]      state,
  input  logic [NUM_ARROWS_BITS:0] cur_arrow,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     game_start,
  output logic [13:0]              score,
  output logic [13:0]              combo_count,
  output logic [13:0]              max_combo,
  output logic                     hit_pulse,
  output logic                     miss_pulse
);

  typedef logic [NUM_ARROWS_BITS:0] arrow_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_JUDGE   = 2'd3;

  localparam int CNT_W = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_DELAY - 1);

  localparam logic [13:0] SAT = 14'(SCORE_MAX);
  localparam logic [STATE_BITS:0] GAME_CODE = STATE_GAME[STATE_BITS:0];

  localparam arrow_t A_UP    = arrow_t'(10);
  localparam arrow_t A_DOWN  = arrow_t'(11);
  localparam arrow_t A_LEFT  = arrow_t'(12);
  localparam arrow_t A_RIGHT = arrow_t'(13);
  localparam arrow_t A_UD    = arrow_t'(14);
  localparam arrow_t A_UL    = arrow_t'(15);
  localparam arrow_t A_UR    = arrow_t'(16);
  localparam arrow_t A_DL    = arrow_t'(17);
  localparam arrow_t A_DR    = arrow_t'(18);
  localparam arrow_t A_LR    = arrow_t'(19);

  // Mask bit order is {up, down, left, right}.
  function automatic logic [3:0] arrow_mask(input arrow_t a);
    case (a)
      A_UP:    return 4'b1000;
      A_DOWN:  return 4'b0100;
      A_LEFT:  return 4'b0010;
      A_RIGHT: return 4'b0001;
      A_UD:    return 4'b1100;
      A_UL:    return 4'b1010;
      A_UR:    return 4'b1001;
      A_DL:    return 4'b0110;
      A_DR:    return 4'b0101;
      A_LR:    return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  logic [2:0]       sync_q;
  logic [3:0]       btn_q;
  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       req_q, req_d;
  logic [3:0]       press_q, press_d;
  logic [13:0]      score_q, score_d;
  logic [13:0]      combo_q, combo_d;
  logic [13:0]      max_q, max_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  logic       beat;
  logic       in_game;
  logic [3:0] btns;
  logic [3:0] rise;
  logic       judge_hit;
  logic       judge_miss;
  logic [13:0] combo_inc;
  logic [13:0] score_inc;

  always_comb begin
    beat       = sync_q[1] & ~sync_q[2];
    in_game    = (state == GAME_CODE);
    btns       = {btn_up, btn_down, btn_left, btn_right};
    rise       = btns & ~btn_q;
    // With an empty required mask any press is a miss, so both cases
    // reduce to a plain mask inequality.
    judge_hit  = (req_q != 4'b0000) && (press_q == req_q);
    judge_miss = (press_q != req_q);
    score_inc  = (score_q >= SAT) ? SAT : score_q + 14'd1;
    combo_inc  = (combo_q >= SAT) ? SAT : combo_q + 14'd1;
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    press_d = press_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (game_start) begin
      score_d = 14'd0;
      combo_d = 14'd0;
      max_d   = 14'd0;
      fsm_d   = S_IDLE;
    end else if (!in_game) begin
      fsm_d = S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (beat) begin
            fsm_d = S_WAIT;
            cnt_d = '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            req_d   = arrow_mask(cur_arrow);
            press_d = 4'b0000;
            fsm_d   = S_COLLECT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_COLLECT: begin
          press_d = press_q | rise;
          if (beat) fsm_d = S_JUDGE;
        end
        S_JUDGE: begin
          if (judge_hit) begin
            score_d = score_inc;
            combo_d = combo_inc;
            max_d   = (combo_inc > max_q) ? combo_inc : max_q;
            hit_d   = 1'b1;
          end else if (judge_miss) begin
            combo_d = 14'd0;
            miss_d  = 1'b1;
          end
          fsm_d = S_WAIT;
          cnt_d = '0;
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 3'b000;
      btn_q   <= 4'b0000;
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 4'b0000;
      press_q <= 4'b0000;
      score_q <= 14'd0;
      combo_q <= 14'd0;
      max_q   <= 14'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], metronome_clk};
      btn_q   <= btns;
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      press_q <= press_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign score       = score_q;
  assign combo_count = combo_q;
  assign max_combo   = max_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_ddr_hit_judge.sv
// tb_ddr_hit_judge: beat-level reference model feeding a scoreboard that a
// pulse monitor drains; random and directed beats, plus score saturation.
module tb_ddr_hit_judge;

  localparam int         SMAX  = 9999;
  localparam logic [1:0] GAME  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd0;

  localparam logic [3:0] MASK_TBL [11] = '{
    4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b1010,
    4'b1001, 4'b0110, 4'b0101, 4'b0011, 4'b0000
  };

  typedef struct {
    bit hit;
    int sc;
    int co;
    int mx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        metronome_clk;
  logic [1:0]  state;
  logic [4:0]  cur_arrow;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        game_start;
  logic [13:0] score, combo_count, max_combo;
  logic        hit_pulse, miss_pulse;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  int       m_score, m_combo, m_max;
  bit       armed;
  logic [3:0] m_req, m_press;

  ddr_hit_judge dut (
    .clk(clk), .rst_n(rst_n), .metronome_clk(metronome_clk),
    .state(state), .cur_arrow(cur_arrow),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .game_start(game_start),
    .score(score), .combo_count(combo_count), .max_combo(max_combo),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] amask(input logic [4:0] a);
    int idx;
    idx = int'(a) - 10;
    if (idx >= 0 && idx <= 10) return MASK_TBL[idx];
    return 4'b0000;
  endfunction

  // One judged beat of the reference game.
  task automatic judge_model(output bit pushed);
    exp_t e;
    pushed = 1'b0;
    if (m_req != 4'b0000 && m_press == m_req) begin
      m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
      m_combo = (m_combo < SMAX) ? m_combo + 1 : SMAX;
      if (m_combo > m_max) m_max = m_combo;
      e.hit = 1'b1;
    end else if ((m_req != 4'b0000 && m_press != m_req) ||
                 (m_req == 4'b0000 && m_press != 4'b0000)) begin
      m_combo = 0;
      e.hit = 1'b0;
    end else begin
      return;
    end
    e.sc = m_score;
    e.co = m_combo;
    e.mx = m_max;
    sb.push_back(e);
    pushed = 1'b1;
  endtask

  // Drives one metronome period starting with its rising edge.
  task automatic period(input int per, input logic [3:0] press,
                        input int poff, input logic [4:0] nxt,
                        input int gs_off, input logic [1:0] st);
    bit pushed;
    pushed = 1'b0;
    state = st;
    if (st != GAME) begin
      armed = 1'b0;
    end else begin
      if (armed && gs_off != 3) judge_model(pushed);
      armed   = 1'b1;
      m_req   = amask(cur_arrow);
      m_press = (poff >= 6) ? press : 4'b0000;
    end
    if (gs_off >= 0) begin
      m_score = 0;
      m_combo = 0;
      m_max   = 0;
      armed   = 1'b0;
    end
    for (int c = 0; c < per; c++) begin
      metronome_clk = (c < per / 2);
      {btn_up, btn_down, btn_left, btn_right} =
        (c == poff) ? press : 4'b0000;
      game_start = (c == gs_off);
      if (c == per - 1) cur_arrow = nxt;
      @(posedge clk);
      #1;
    end
    if (pushed) begin
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL pulse_missing: %0d pending, required 0", sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic check_outputs(input string nm);
    vectors++;
    if (int'(score) != m_score) begin
      miscompares++;
      $display("FAIL %s score: got %0d, want %0d", nm, score, m_score);
    end
    vectors++;
    if (int'(combo_count) != m_combo) begin
      miscompares++;
      $display("FAIL %s combo: got %0d, want %0d", nm, combo_count, m_combo);
    end
    vectors++;
    if (int'(max_combo) != m_max) begin
      miscompares++;
      $display("FAIL %s max: got %0d, want %0d", nm, max_combo, m_max);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    metronome_clk = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    game_start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
    armed   = 1'b0;
    check_outputs("reset");
    vectors++;
    if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset pulses: got %b%b, want 00", hit_pulse, miss_pulse);
    end
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (hit_pulse || miss_pulse)) begin
      vectors++;
      if (hit_pulse && miss_pulse) begin
        miscompares++;
        $display("FAIL both_pulses: got hit=1 miss=1, want one");
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_pulse: got hit=%0b miss=%0b, want none",
                 hit_pulse, miss_pulse);
      end else begin
        mon_e = sb.pop_front();
        if (hit_pulse != mon_e.hit || int'(score) != mon_e.sc ||
            int'(combo_count) != mon_e.co || int'(max_combo) != mon_e.mx) begin
          miscompares++;
          $display("FAIL judge: got hit=%0b s=%0d c=%0d m=%0d, want hit=%0b s=%0d c=%0d m=%0d",
                   hit_pulse, score, combo_count, max_combo,
                   mon_e.hit, mon_e.sc, mon_e.co, mon_e.mx);
        end
      end
    end
  end

  initial begin
    state = PAUSE;
    cur_arrow = 5'd10;
    do_reset();

    state = GAME;
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 7, 5'd10, -1, GAME);
    period(12, 4'b1000, 9, 5'd14, -1, GAME);
    check_outputs("two_hits");
    period(12, 4'b1000, 8, 5'd20, -1, GAME);
    period(12, 4'b0000, 8, 5'd20, -1, GAME);
    check_outputs("after_miss");
    period(12, 4'b0010, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    check_outputs("none_then_miss");

    do_reset();
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    check_outputs("pre_start");
    period(12, 4'b1000, 6, 5'd10, 3, GAME);
    check_outputs("game_start");
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 6, 5'd10, -1, GAME);
    period(12, 4'b1000, 6, 5'd10, -1, PAUSE);
    check_outputs("pause_hold");

    for (int i = 0; i < 150; i++) begin
      int per, r, po, gs;
      logic [4:0] nxt;
      logic [3:0] pr;
      logic [1:0] st;
      per = $urandom_range(16, 9);
      r = $urandom_range(15, 0);
      nxt = (r < 11) ? 5'(10 + r) : 5'($urandom_range(31, 0));
      pr = ($urandom_range(1, 0) == 1) ? amask(cur_arrow)
                                       : 4'($urandom_range(15, 0));
      po = $urandom_range(per - 1, 3);
      if (po == 5) po = 6;
      gs = ($urandom_range(99, 0) < 4) ? $urandom_range(per - 1, 3) : -1;
      st = ($urandom_range(99, 0) < 6) ? PAUSE : GAME;
      period(per, pr, po, nxt, gs, st);
      if (i % 25 == 24) check_outputs("random");
    end

    cur_arrow = 5'd10;
    period(7, 4'b0000, 6, 5'd10, 3, GAME);
    while (m_score < SMAX - 1) period(7, 4'b1000, 6, 5'd10, -1, GAME);
    check_outputs("sat_pre");
    repeat (3) period(7, 4'b1000, 6, 5'd10, -1, GAME);
    check_outputs("sat");
    period(7, 4'b0000, 6, 5'd10, -1, GAME);
    repeat (3) period(7, 4'b1000, 6, 5'd10, -1, GAME);
    period(7, 4'b0000, 6, 5'd10, -1, GAME);
    check_outputs("sat_post");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
